pc_fetch_unit: RTL and testbench

//   Fetch stage directly downstream of the next-PC logic. Owns the program-counter register and fetches
//   one 32-bit instruction per PC over a valid/ready instruction-memory port, then holds it for decode.

---
 rtl/fetch_pkg.sv | 7 +
 rtl/pc_fetch_unit_if.sv | 27 ++
 rtl/pc_register.sv | 15 +
 rtl/pc_fetch_unit.sv | 63 ++++++
 tb/tb_pc_fetch_unit.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and default widths for the fetch stage.
package fetch_pkg;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_FAULT} fetch_state_t;
  localparam int ADDR_W_DEF = 64;
  localparam int INST_W_DEF = 32;
  localparam logic [63:0] RESET_PC_DEF = 64'h0;
endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: next-PC, instruction-memory and decode handshake signals of the fetch stage.
interface pc_fetch_unit_if #(
  parameter int ADDR_W = fetch_pkg::ADDR_W_DEF,
  parameter int INST_W = fetch_pkg::INST_W_DEF
);
  logic              Halt;
  logic [ADDR_W-1:0] NextPC;
  logic [ADDR_W-1:0] CurrentPC;
  logic              IMemReqValid;
  logic              IMemReqReady;
  logic [ADDR_W-1:0] IMemAddr;
  logic              IMemRespValid;
  logic [INST_W-1:0] IMemRdData;
  logic              InstValid;
  logic              InstReady;
  logic [INST_W-1:0] InstOut;
  logic [ADDR_W-1:0] InstPC;
  logic              Fault;
  modport master (
    input  Halt, NextPC, IMemReqReady, IMemRespValid, IMemRdData, InstReady,
    output CurrentPC, IMemReqValid, IMemAddr, InstValid, InstOut, InstPC, Fault
  );
  modport slave (
    output Halt, NextPC, IMemReqReady, IMemRespValid, IMemRdData, InstReady,
    input  CurrentPC, IMemReqValid, IMemAddr, InstValid, InstOut, InstPC, Fault
  );
endinterface

// File: rtl/pc_register.sv
// pc_register: program-counter register with load enable and reset value.
module pc_register #(
  parameter int ADDR_W = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] d,
  output logic [ADDR_W-1:0] q
);
  always_ff @(posedge CLK)
    if (Reset) q <= RESET_PC;
    else if (load) q <= d;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the PC, fetches one instruction per PC and holds it for decode.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned PCs into a sticky fault state.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INST_W = INST_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input logic CLK,
  input logic Reset,
  pc_fetch_unit_if.master bus
);
  fetch_state_t      state;
  logic [INST_W-1:0] inst;
  logic              load;
  assign load = (state == S_HOLD) && bus.InstReady;
  pc_register #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
    .CLK(CLK), .Reset(Reset), .load(load), .d(bus.NextPC), .q(bus.CurrentPC)
  );
`ifdef FETCH_ALIGN_CHECK_EN
  logic fault;
  assign bus.Fault = fault;
`else
  assign bus.Fault = 1'b0;
`endif
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= S_IDLE;
      inst  <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE:
          if (!bus.Halt) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (bus.CurrentPC[1:0] != 2'b00) begin
              state <= S_FAULT;
              fault <= 1'b1;
            end else state <= S_REQ;
`else
            state <= S_REQ;
`endif
          end
        S_REQ: if (bus.IMemReqReady) state <= S_WAIT;
        S_WAIT:
          if (bus.IMemRespValid) begin
            inst  <= bus.IMemRdData;
            state <= S_HOLD;
          end
        S_HOLD: if (bus.InstReady) state <= S_IDLE;
        default: state <= state;
      endcase
    end
  end
  assign bus.IMemReqValid = state == S_REQ;
  assign bus.IMemAddr     = {bus.CurrentPC[ADDR_W-1:2], 2'b00};
  assign bus.InstValid    = state == S_HOLD;
  assign bus.InstOut      = inst;
  assign bus.InstPC       = bus.CurrentPC;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed and randomized checks of the fetch stage against a transaction-level model.
module tb_pc_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pc_fetch_unit_if #(.ADDR_W(64), .INST_W(32)) bus();
  pc_fetch_unit #(.ADDR_W(64), .INST_W(32), .RESET_PC(64'h0)) dut (.CLK(clk), .Reset(rst), .bus(bus));
  int tests = 0;
  int fails = 0;
  logic [63:0] exp_pc;
  logic [31:0] last_inst;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0F0F;
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    bus.Halt = 1'b0; bus.NextPC = '0; bus.IMemReqReady = 1'b0;
    bus.IMemRespValid = 1'b0; bus.IMemRdData = '0; bus.InstReady = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!bus.IMemReqValid && n < 10) begin
      tick;
      n++;
    end
  endtask

  task automatic test_reset;
    idle_inputs;
    do_reset;
    tests++; if (bus.CurrentPC !== 64'h0) begin fails++; $display("FAIL reset_pc got %h want 0", bus.CurrentPC); end
    tests++; if (bus.IMemReqValid !== 1'b0) begin fails++; $display("FAIL reset_reqvalid got %b want 0", bus.IMemReqValid); end
    tests++; if (bus.InstValid !== 1'b0) begin fails++; $display("FAIL reset_instvalid got %b want 0", bus.InstValid); end
    tests++; if (bus.InstOut !== 32'h0) begin fails++; $display("FAIL reset_instout got %h want 0", bus.InstOut); end
    tests++; if (bus.Fault !== 1'b0) begin fails++; $display("FAIL reset_fault got %b want 0", bus.Fault); end
    exp_pc = 64'h0;
  endtask

  task automatic test_sequential;
    int n;
    bus.IMemReqReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_req(n);
      tests++; if (n != 1) begin fails++; $display("FAIL seq_req_latency got %0d want 1", n); end
      tests++; if (bus.IMemAddr !== exp_pc) begin fails++; $display("FAIL seq_addr got %h want %h", bus.IMemAddr, exp_pc); end
      tick;
      bus.IMemRespValid = 1'b1; bus.IMemRdData = 32'hF84003E9;
      tick;
      bus.IMemRespValid = 1'b0;
      tests++; if (bus.InstValid !== 1'b1 || bus.InstOut !== 32'hF84003E9 || bus.InstPC !== exp_pc) begin
        fails++; $display("FAIL seq_inst got v=%b %h pc=%h want v=1 f84003e9 pc=%h", bus.InstValid, bus.InstOut, bus.InstPC, exp_pc);
      end
      bus.NextPC = exp_pc + 64'd4; bus.InstReady = 1'b1;
      tick;
      bus.InstReady = 1'b0;
      exp_pc = exp_pc + 64'd4;
      tests++; if (bus.CurrentPC !== exp_pc || bus.InstValid !== 1'b0) begin
        fails++; $display("FAIL seq_pc_step got %h v=%b want %h v=0", bus.CurrentPC, bus.InstValid, exp_pc);
      end
    end
    bus.IMemReqReady = 1'b0;
  endtask

  task automatic test_req_stall;
    int n;
    wait_req(n);
    tests++; if (n >= 10) begin fails++; $display("FAIL stall_req_timeout got none want request"); end
    for (int i = 0; i < 5; i++) begin
      tests++; if (bus.IMemReqValid !== 1'b1 || bus.IMemAddr !== exp_pc) begin
        fails++; $display("FAIL stall_hold got v=%b %h want v=1 %h", bus.IMemReqValid, bus.IMemAddr, exp_pc);
      end
      tick;
    end
    bus.IMemReqReady = 1'b1;
    tick;
    bus.IMemReqReady = 1'b0;
    tests++; if (bus.IMemReqValid !== 1'b0) begin fails++; $display("FAIL stall_single_accept got %b want 0", bus.IMemReqValid); end
  endtask

  task automatic test_hold_stall;
    last_inst = $urandom;
    bus.IMemRespValid = 1'b1; bus.IMemRdData = last_inst;
    tick;
    bus.IMemRespValid = 1'b0;
    bus.NextPC = 64'h40; bus.InstReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++; if (bus.InstValid !== 1'b1 || bus.InstOut !== last_inst || bus.CurrentPC !== exp_pc) begin
        fails++; $display("FAIL hold_stall got v=%b %h pc=%h want v=1 %h pc=%h", bus.InstValid, bus.InstOut, bus.CurrentPC, last_inst, exp_pc);
      end
      bus.IMemRespValid = (i == 1); bus.IMemRdData = 32'hDEADBEEF;
      tick;
      bus.IMemRespValid = 1'b0;
    end
    bus.InstReady = 1'b1;
    tick;
    bus.InstReady = 1'b0;
    exp_pc = 64'h40;
    tests++; if (bus.CurrentPC !== 64'h40) begin fails++; $display("FAIL hold_accept_pc got %h want 40", bus.CurrentPC); end
  endtask

  task automatic test_spurious;
    bus.Halt = 1'b1;
    bus.IMemRespValid = 1'b1; bus.IMemRdData = 32'hDEADBEEF;
    tick;
    bus.IMemRespValid = 1'b0;
    tick;
    tests++; if (bus.IMemReqValid !== 1'b0) begin fails++; $display("FAIL halt_no_req got %b want 0", bus.IMemReqValid); end
    tests++; if (bus.InstOut !== last_inst) begin fails++; $display("FAIL spurious_idle got %h want %h", bus.InstOut, last_inst); end
    bus.Halt = 1'b0;
  endtask

  task automatic test_reset_mid;
    int n;
    wait_req(n);
    bus.IMemReqReady = 1'b1;
    tick;
    bus.IMemReqReady = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    bus.IMemRespValid = 1'b1; bus.IMemRdData = 32'hDEADBEEF;
    tick;
    bus.IMemRespValid = 1'b0;
    tests++; if (bus.CurrentPC !== 64'h0 || bus.InstOut !== 32'h0 || bus.InstValid !== 1'b0) begin
      fails++; $display("FAIL reset_mid got pc=%h %h v=%b want pc=0 0 v=0", bus.CurrentPC, bus.InstOut, bus.InstValid);
    end
    wait_req(n);
    tests++; if (n >= 10 || bus.IMemAddr !== 64'h0) begin fails++; $display("FAIL reset_mid_refetch got %h n=%0d want 0", bus.IMemAddr, n); end
  endtask

  task automatic test_random;
    logic [63:0] m_pc, req_addr;
    logic [31:0] exp_data;
    bit inflight, held;
    int delay, delivered;
    idle_inputs;
    do_reset;
    m_pc = 64'h0; inflight = 0; held = 0; delay = 0; delivered = 0; exp_data = '0; req_addr = '0;
    for (int c = 0; c < 3000; c++) begin
      tests++; if (bus.CurrentPC !== m_pc) begin fails++; $display("FAIL rnd_pc c=%0d got %h want %h", c, bus.CurrentPC, m_pc); end
      tests++; if (bus.InstValid !== held) begin fails++; $display("FAIL rnd_instvalid c=%0d got %b want %b", c, bus.InstValid, held); end
      if (held) begin
        tests++; if (bus.InstOut !== exp_data || bus.InstPC !== m_pc) begin
          fails++; $display("FAIL rnd_inst c=%0d got %h pc=%h want %h pc=%h", c, bus.InstOut, bus.InstPC, exp_data, m_pc);
        end
      end
      if (bus.IMemReqValid) begin
        tests++; if (inflight || held || bus.IMemAddr !== {m_pc[63:2], 2'b00}) begin
          fails++; $display("FAIL rnd_req c=%0d got %h busy=%b want %h busy=0", c, bus.IMemAddr, inflight | held, {m_pc[63:2], 2'b00});
        end
      end
      bus.Halt = ($urandom_range(0, 3) == 0);
      bus.IMemReqReady = $urandom_range(0, 1) == 1;
      bus.InstReady = $urandom_range(0, 1) == 1;
      bus.NextPC = $urandom_range(0, 1) ? m_pc + 64'd4 : {$urandom, $urandom} & ~64'h3;
      if (held && bus.InstReady) begin
        m_pc = bus.NextPC;
        held = 0;
        delivered++;
      end
      if (inflight && delay == 0) begin
        bus.IMemRespValid = 1'b1; bus.IMemRdData = mem_word(req_addr);
        exp_data = mem_word({m_pc[63:2], 2'b00});
        inflight = 0;
        held = 1;
      end else begin
        bus.IMemRespValid = !inflight && ($urandom_range(0, 9) == 0);
        bus.IMemRdData = $urandom;
        if (inflight) delay--;
      end
      if (bus.IMemReqValid && bus.IMemReqReady) begin
        inflight = 1;
        delay = $urandom_range(0, 3);
        req_addr = bus.IMemAddr;
      end
      tick;
    end
    tests++; if (delivered < 50) begin fails++; $display("FAIL rnd_progress got %0d want >=50", delivered); end
    idle_inputs;
  endtask

  task automatic test_align;
    int n;
    idle_inputs;
    do_reset;
    bus.IMemReqReady = 1'b1;
    wait_req(n);
    tick;
    bus.IMemReqReady = 1'b0;
    bus.IMemRespValid = 1'b1; bus.IMemRdData = 32'h12345678;
    tick;
    bus.IMemRespValid = 1'b0;
    bus.NextPC = 64'h6; bus.InstReady = 1'b1;
    tick;
    bus.InstReady = 1'b0;
    tests++; if (bus.CurrentPC !== 64'h6) begin fails++; $display("FAIL align_pc got %h want 6", bus.CurrentPC); end
    bus.IMemReqReady = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
    tick;
    for (int i = 0; i < 4; i++) begin
      tests++; if (bus.Fault !== 1'b1 || bus.IMemReqValid !== 1'b0 || bus.InstValid !== 1'b0) begin
        fails++; $display("FAIL align_fault got f=%b rv=%b iv=%b want f=1 rv=0 iv=0", bus.Fault, bus.IMemReqValid, bus.InstValid);
      end
      tick;
    end
`else
    wait_req(n);
    tests++; if (n >= 10 || bus.IMemAddr !== 64'h4 || bus.Fault !== 1'b0) begin
      fails++; $display("FAIL align_mask got %h f=%b n=%0d want 4 f=0", bus.IMemAddr, bus.Fault, n);
    end
`endif
    bus.IMemReqReady = 1'b0;
  endtask

  initial begin
    test_reset;
    test_sequential;
    test_req_stall;
    test_hold_stall;
    test_spurious;
    test_reset_mid;
    test_random;
    test_align;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
